count_checker: RTL

Sequence checker for the parameterised up/down counter: it sits on the counter's output bus and the same `dir` control. It tracks what the counter should produce cycle by cycle, locks onto a valid stream and flags every step that breaks the ±1 modulo-2^cw rule. The block is used in self-checking benches and as an on-chip monitor next to `counter`.

---
 rtl/count_checker.sv | 110 +++++++++++
 1 files changed

// File: rtl/count_checker.sv
// Sequence checker for an up/down counter: locks onto a +/-1 modulo-2^cw stream
// and flags every broken step while locked, with a saturating error count.
module count_checker #(
  parameter int unsigned cw     = 8,
  parameter int unsigned ew     = 16,
  parameter int unsigned lock_n = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic          dir,
  input  logic [cw-1:0] c_in,
  output logic          locked,
  output logic          err,
  output logic [ew-1:0] err_cnt,
  output logic [cw-1:0] exp_out
);

  localparam logic [0:0] ACQUIRE = 1'b0;
  localparam logic [0:0] TRACK   = 1'b1;

  localparam logic [7:0] lock_lim = 8'(lock_n);

  logic [0:0]    state_q, state_d;
  logic [cw-1:0] last_q, last_d;
  logic          last_dir_q, last_dir_d;
  logic          have_q, have_d;
  logic [7:0]    match_cnt_q, match_cnt_d;
  logic          err_q, err_d;
  logic [ew-1:0] err_cnt_q, err_cnt_d;
  logic [cw-1:0] exp_q, exp_d;

  logic [cw-1:0] step_exp;
  logic          hit;

  // Step predicted from the last accepted sample and the direction captured with it.
  assign step_exp = last_dir_q ? last_q + cw'(1) : last_q - cw'(1);
  assign hit      = (c_in == step_exp);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    last_dir_d  = last_dir_q;
    have_d      = have_q;
    match_cnt_d = match_cnt_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    exp_d       = exp_q;

    if (en) begin
      last_d     = c_in;
      last_dir_d = dir;
      have_d     = 1'b1;
      exp_d      = dir ? c_in + cw'(1) : c_in - cw'(1);

      if (state_q == ACQUIRE) begin
        // The very first sample after reset has nothing to be compared against.
        if (have_q) begin
          if (hit) begin
            if (match_cnt_q + 8'd1 == lock_lim) begin
              state_d     = TRACK;
              match_cnt_d = 8'd0;
            end else begin
              match_cnt_d = match_cnt_q + 8'd1;
            end
          end else begin
            match_cnt_d = 8'd0;
          end
        end
      end else begin
        if (!hit) begin
          err_d       = 1'b1;
          state_d     = ACQUIRE;
          match_cnt_d = 8'd0;
          if (err_cnt_q != {ew{1'b1}}) begin
            err_cnt_d = err_cnt_q + ew'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ACQUIRE;
      last_q      <= '0;
      last_dir_q  <= 1'b0;
      have_q      <= 1'b0;
      match_cnt_q <= 8'd0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      exp_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      last_dir_q  <= last_dir_d;
      have_q      <= have_d;
      match_cnt_q <= match_cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      exp_q       <= exp_d;
    end
  end

  assign locked  = (state_q == TRACK);
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign exp_out = exp_q;

endmodule
